uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Configurable UART transmitter: FIFO-buffered, runtime-selectable data length, parity and stop bits.
//  Frames are sent LSB first on tx_o. It succeeds the fixed 8N1 transmitter in peripheral UART
//  subsystems and is fed by a bus register interface (push on tx_we_i).
// PARAMETERS
//  MAX_DATA_WIDTH  8   widest data field supported (5..MAX_DATA_WIDTH selectable)
//  FIFO_DEPTH      16  TX buffer depth in words (power of 2)
// PORTS
//  clk_i        in   1               single clock, rising edge
//  rst_i        in   1               asynchronous, active-high reset
//  baud_div_i   in   16              clock cycles per bit; 0 and 1 both mean 1 cycle
//  tx_en_i      in   1               allow new frames to start
//  tx_we_i      in   1               push din_i into FIFO
//  din_i        in   MAX_DATA_WIDTH  word to send; bits above data length ignored
//  data_len_i   in   4               data bits per frame; <5 clamps to 5, >MAX_DATA_WIDTH clamps to max
//  parity_i     in   2               00 none, 01 even, 10 odd, 11 none
//  stop2_i      in   1               0: 1 stop bit, 1: 2 stop bits
//  ovf_clr_i    in   1               clear overflow_o
//  tx_o         out  1               serial line, idle high
//  busy_o       out  1               frame in progress (state != IDLE)
//  done_o       out  1               1-cycle pulse in last cycle of final stop bit
//  empty_o      out  1               FIFO empty
//  full_o       out  1               FIFO full
//  overflow_o   out  1               sticky: push attempted while full
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, tx_o=1, busy_o=0, done_o=0, overflow_o=0, FIFO empty, counters 0.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//   IDLE: if tx_en_i && !empty_o, assert rd_en for 1 cycle, go to START.
//   START: tx_o=0. The first START cycle latches the FIFO read data (valid the cycle after rd_en)
//     into the shift register. It also latches data_len_i/parity_i/stop2_i into frame config.
//   DATA: tx_o=shift[0]; shift right every bit period; leave after len bits.
//   PARITY (only if enabled): tx_o = XOR(data bits) for even, ~XOR for odd.
//   STOP: tx_o=1 for 1 or 2 bit periods. At the end, done_o pulses. If tx_en_i && !empty_o,
//     pop and go straight to START with no idle gap; else go to IDLE.
//  Bit timing: baud_cnt counts 0..max(baud_div_i,1)-1 in non-IDLE states and is held 0 in IDLE.
//   Bit advance occurs on the terminal count. bit_cnt counts data and stop bits.
//  Config inputs and baud_div_i changes affect only the next frame.
//   Exception: baud_div_i is sampled per bit (documented limitation).
//  tx_en_i deassert mid-frame: the current frame completes, and no further pop occurs.
//  FIFO: push accepted only when !full_o, even if a pop occurs in the same cycle.
//   A push while full is dropped and sets overflow_o. Set has priority over a simultaneous ovf_clr_i.
//  Simultaneous push and pop when not full/empty: both performed; occupancy unchanged.
//  Latency: push into an empty FIFO while idle and enabled -> tx_o falls 3 clk_i edges later
//   (push edge, pop edge, START entry).
//  Frame length in cycles: (1 + len + par + stops) * max(baud_div_i,1).
// STRUCTURE
//  uart_pkg: typedef enum logic[2:0] tx_state_e {IDLE,START,DATA,PARITY,STOP}.
//   Also typedef enum logic[1:0] parity_e {PAR_NONE,PAR_EVEN,PAR_ODD,PAR_NONE2}, plus
//   localparam MIN_DATA_WIDTH=5 and a clamp_len() function.
//  Sub-module: wbit_fifo (existing), DATA_WIDTH=MAX_DATA_WIDTH, rst tied to rst_i.
//  One comb next-state/output block and one always_ff with async rst_i.
// TESTING
//  1. baud_div=4, len=8, par none, 1 stop, push 0xA5 -> tx_o: 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
//     done_o pulses at cycle 40 of the frame.
//  2. len=7, even, 2 stop, push 0x41 -> 0,1,0,0,0,0,0,1, parity 0, 1,1 (11 bits).
//     Repeat with odd parity -> parity bit 1.
//  3. len=5, odd, push 0x1F and 0xE0 back-to-back -> two frames (0x1F parity 0, 0x00 parity 1).
//     No idle cycle between the frames; busy_o stays high throughout.
//  4. tx_en=0, push 17 words (depth 16) -> full_o=1, overflow_o=1, 17th word lost.
//     ovf_clr_i clears overflow_o. Enable -> exactly 16 frames, then empty_o=1.
//  5. baud_div=0 and baud_div=1 -> 1 cycle/bit. Drop tx_en mid-frame -> frame completes, next word stays queued.
//  6. Assert rst_i mid-DATA -> tx_o=1 and busy_o=0 before next clk edge; FIFO empty after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Frame sequencing states, parity modes and data-length clamping live here.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_EVEN  = 2'd1,
        PAR_ODD   = 2'd2,
        PAR_NONE2 = 2'd3
    } parity_e;

    localparam int MIN_DATA_WIDTH = 5;
    localparam int PAR_CALC_W     = 16;

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len < 4'(MIN_DATA_WIDTH)) begin
            clamp_len = 4'(MIN_DATA_WIDTH);
        end else if (len > max_len) begin
            clamp_len = max_len;
        end else begin
            clamp_len = len;
        end
    endfunction

    // Bits above the frame length must already be zeroed by the caller.
    function automatic logic parity_bit(input logic [PAR_CALC_W-1:0] data, input parity_e mode);
        case (mode)
            PAR_EVEN: parity_bit = ^data;
            PAR_ODD:  parity_bit = ~(^data);
            default:  parity_bit = 1'b0;
        endcase
    endfunction

    function automatic logic parity_en(input parity_e mode);
        parity_en = (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/wbit_fifo.sv
// Synchronous FIFO with registered read data (valid the cycle after rd_en_i).
// Writes while full and reads while empty are ignored.
module wbit_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_wr;
    logic                  w_rd;

    assign empty_o   = (r_count == (AW+1)'(0));
    assign full_o    = (r_count == (AW+1)'(DEPTH));
    assign w_wr      = wr_en_i && !full_o;
    assign w_rd      = rd_en_i && !empty_o;
    assign rd_data_o = r_rd_data;

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// FIFO-buffered UART transmitter with per-frame data length, parity and stop-bit selection.
// All serial outputs are registered, so the line lags the state register by one cycle.
module uart_tx_cfg #(
    parameter int MAX_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [15:0]               baud_div_i,
    input  logic                      tx_en_i,
    input  logic                      tx_we_i,
    input  logic [MAX_DATA_WIDTH-1:0] din_i,
    input  logic [3:0]                data_len_i,
    input  logic [1:0]                parity_i,
    input  logic                      stop2_i,
    input  logic                      ovf_clr_i,
    output logic                      tx_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      overflow_o
);

    import uart_pkg::*;

    tx_state_e                 r_state, w_state_nxt;
    logic [15:0]               r_baud_cnt, w_baud_cnt_nxt;
    logic [3:0]                r_bit_cnt, w_bit_cnt_nxt;
    logic [MAX_DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [3:0]                r_len, w_len_nxt;
    parity_e                   r_par, w_par_nxt;
    logic                      r_stop2, w_stop2_nxt;
    logic                      r_par_bit, w_par_bit_nxt;
    logic                      r_tx, r_busy, r_done, r_ovf;
    logic                      w_tx, w_done, w_ovf_nxt, w_rd_en, w_push;
    logic [15:0]               w_div_eff;
    logic                      w_bit_end;
    logic [3:0]                w_len_cfg;
    parity_e                   w_par_cfg;
    logic [MAX_DATA_WIDTH-1:0] w_rd_data, w_masked;
    logic                      w_fifo_empty, w_fifo_full;

    assign w_div_eff  = (baud_div_i > 16'd1) ? baud_div_i : 16'd1;
    assign w_bit_end  = (r_baud_cnt >= (w_div_eff - 16'd1));
    assign w_len_cfg  = clamp_len(data_len_i, 4'(MAX_DATA_WIDTH));
    assign w_par_cfg  = parity_e'(parity_i);
    assign w_push     = tx_we_i && !w_fifo_full;

    assign tx_o       = r_tx;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign overflow_o = r_ovf;
    assign empty_o    = w_fifo_empty;
    assign full_o     = w_fifo_full;

    wbit_fifo #(
        .DATA_WIDTH (MAX_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (w_push),
        .wr_data_i (din_i),
        .rd_en_i   (w_rd_en),
        .rd_data_o (w_rd_data),
        .empty_o   (w_fifo_empty),
        .full_o    (w_fifo_full)
    );

    // Frame sequencing: next state, counters, frame config capture and line value.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_len_nxt      = r_len;
        w_par_nxt      = r_par;
        w_stop2_nxt    = r_stop2;
        w_par_bit_nxt  = r_par_bit;
        w_rd_en        = 1'b0;
        w_tx           = 1'b1;
        w_done         = 1'b0;
        w_baud_cnt_nxt = 16'd0;
        w_masked       = '0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            w_masked[i] = (4'(i) < w_len_cfg) ? w_rd_data[i] : 1'b0;
        end

        if (r_state == IDLE) begin
            w_baud_cnt_nxt = 16'd0;
        end else if (w_bit_end) begin
            w_baud_cnt_nxt = 16'd0;
        end else begin
            w_baud_cnt_nxt = r_baud_cnt + 16'd1;
        end

        // An overflow set wins over a clear in the same cycle.
        if (tx_we_i && w_fifo_full) begin
            w_ovf_nxt = 1'b1;
        end else if (ovf_clr_i) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf;
        end

        case (r_state)
            IDLE: begin
                w_tx = 1'b1;
                if (tx_en_i && !w_fifo_empty) begin
                    w_rd_en       = 1'b1;
                    w_bit_cnt_nxt = 4'd0;
                    w_state_nxt   = START;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            START: begin
                w_tx = 1'b0;
                if (r_baud_cnt == 16'd0) begin
                    w_shift_nxt   = w_masked;
                    w_len_nxt     = w_len_cfg;
                    w_par_nxt     = w_par_cfg;
                    w_stop2_nxt   = stop2_i;
                    w_par_bit_nxt = parity_bit({{(PAR_CALC_W-MAX_DATA_WIDTH){1'b0}}, w_masked}, w_par_cfg);
                end else begin
                    w_shift_nxt   = r_shift;
                end
                if (w_bit_end) begin
                    w_bit_cnt_nxt = 4'd0;
                    w_state_nxt   = DATA;
                end else begin
                    w_state_nxt   = START;
                end
            end
            DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[MAX_DATA_WIDTH-1:1]};
                    if (r_bit_cnt == (r_len - 4'd1)) begin
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = parity_en(r_par) ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY: begin
                w_tx = r_par_bit;
                if (w_bit_end) begin
                    w_bit_cnt_nxt = 4'd0;
                    w_state_nxt   = STOP;
                end else begin
                    w_state_nxt   = PARITY;
                end
            end
            STOP: begin
                w_tx = 1'b1;
                if (w_bit_end) begin
                    if (r_bit_cnt == {3'b000, r_stop2}) begin
                        w_done        = 1'b1;
                        w_bit_cnt_nxt = 4'd0;
                        if (tx_en_i && !w_fifo_empty) begin
                            w_rd_en     = 1'b1;
                            w_state_nxt = START;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_tx        = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters, frame config and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= '0;
            r_len      <= 4'(MIN_DATA_WIDTH);
            r_par      <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_len      <= w_len_nxt;
            r_par      <= w_par_nxt;
            r_stop2    <= w_stop2_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_tx       <= w_tx;
            r_busy     <= (r_state != IDLE);
            r_done     <= w_done;
            r_ovf      <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed scenarios plus randomized frames
// compared cycle by cycle against a bit-list model of the serial frame.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        tx_en;
    logic        tx_we;
    logic [7:0]  din;
    logic [3:0]  data_len;
    logic [1:0]  parity;
    logic        stop2;
    logic        ovf_clr;
    logic        tx_o, busy_o, done_o, empty_o, full_o, overflow_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.MAX_DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .baud_div_i (baud_div),
        .tx_en_i    (tx_en),
        .tx_we_i    (tx_we),
        .din_i      (din),
        .data_len_i (data_len),
        .parity_i   (parity),
        .stop2_i    (stop2),
        .ovf_clr_i  (ovf_clr),
        .tx_o       (tx_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .overflow_o (overflow_o)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input int div, input int len, input int par, input bit s2);
        baud_div = 16'(div);
        data_len = 4'(len);
        parity   = 2'(par);
        stop2    = s2;
    endtask

    task automatic push(input logic [7:0] w);
        tx_we = 1'b1;
        din   = w;
        @(negedge clk);
        tx_we = 1'b0;
    endtask

    // Waits (bounded) for the start bit, then checks every cycle of the frame.
    task automatic expect_frame(input logic [7:0] w, input int div, input int len_raw,
                                input int par, input bit s2, input string name,
                                output int waited);
        bit bits[$];
        int len, ones, de;
        len  = (len_raw < 5) ? 5 : ((len_raw > 8) ? 8 : len_raw);
        de   = (div <= 1) ? 1 : div;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (par == 1) bits.push_back(bit'(ones % 2));
        if (par == 2) bits.push_back(bit'(1 - (ones % 2)));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);

        waited = 0;
        while (tx_o === 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (tx_o !== 1'b0) begin
            bad++;
            $display("FAIL %s start: tx_o=%b after %0d cycles, required 0", name, tx_o, waited);
            return;
        end
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < de; c++) begin
                total += 3;
                if (tx_o !== bits[b]) begin
                    bad++;
                    $display("FAIL %s tx bit%0d cyc%0d: got %b want %b", name, b, c, tx_o, bits[b]);
                end
                if (busy_o !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy bit%0d cyc%0d: got %b want 1", name, b, c, busy_o);
                end
                if (done_o !== ((b == bits.size() - 1) && (c == de - 1))) begin
                    bad++;
                    $display("FAIL %s done bit%0d cyc%0d: got %b", name, b, c, done_o);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        total += 6;
        if (tx_o !== 1'b1)       begin bad++; $display("FAIL reset tx_o: got %b want 1", tx_o); end
        if (busy_o !== 1'b0)     begin bad++; $display("FAIL reset busy: got %b want 0", busy_o); end
        if (done_o !== 1'b0)     begin bad++; $display("FAIL reset done: got %b want 0", done_o); end
        if (empty_o !== 1'b1)    begin bad++; $display("FAIL reset empty: got %b want 1", empty_o); end
        if (full_o !== 1'b0)     begin bad++; $display("FAIL reset full: got %b want 0", full_o); end
        if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset ovf: got %b want 0", overflow_o); end
    endtask

    task automatic test_basic;
        int n, w;
        set_cfg(4, 8, 0, 1'b0);
        tx_en = 1'b1;
        @(negedge clk);
        push(8'hA5);
        n = 1;
        while (tx_o === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 3) begin bad++; $display("FAIL latency: tx_o fell %0d edges after push, want 3", n); end
        expect_frame(8'hA5, 4, 8, 0, 1'b0, "basic_a5", w);
        total += 2;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL basic idle busy: got %b want 0", busy_o); end
        if (tx_o !== 1'b1)   begin bad++; $display("FAIL basic idle tx: got %b want 1", tx_o); end
    endtask

    task automatic test_parity;
        int w;
        set_cfg(2, 7, 1, 1'b1);
        push(8'h41);
        expect_frame(8'h41, 2, 7, 1, 1'b1, "even_41", w);
        repeat (2) @(negedge clk);
        set_cfg(2, 7, 2, 1'b1);
        push(8'h41);
        expect_frame(8'h41, 2, 7, 2, 1'b1, "odd_41", w);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int w1, w2;
        set_cfg(3, 5, 2, 1'b0);
        push(8'h1F);
        push(8'hE0);
        expect_frame(8'h1F, 3, 5, 2, 1'b0, "b2b_1f", w1);
        expect_frame(8'hE0, 3, 5, 2, 1'b0, "b2b_e0", w2);
        total++;
        if (w2 != 0) begin bad++; $display("FAIL b2b gap: got %0d idle cycles want 0", w2); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fifo_full;
        logic [7:0] q[$];
        logic [7:0] w;
        int wt;
        bit idle_ok;
        tx_en = 1'b0;
        set_cfg(1, 8, 0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            w = 8'($urandom);
            if (i < 16) q.push_back(w);
            push(w);
        end
        total += 3;
        if (full_o !== 1'b1)     begin bad++; $display("FAIL fifo full: got %b want 1", full_o); end
        if (overflow_o !== 1'b1) begin bad++; $display("FAIL fifo ovf set: got %b want 1", overflow_o); end
        if (empty_o !== 1'b0)    begin bad++; $display("FAIL fifo empty: got %b want 0", empty_o); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        total++;
        if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf clear: got %b want 0", overflow_o); end
        tx_we   = 1'b1;
        din     = 8'h99;
        ovf_clr = 1'b1;
        @(negedge clk);
        tx_we   = 1'b0;
        ovf_clr = 1'b0;
        total++;
        if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf set priority: got %b want 1", overflow_o); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        tx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_frame(q[i], 1, 8, 0, 1'b0, $sformatf("fifo%0d", i), wt);
            if (i > 0) begin
                total++;
                if (wt != 0) begin bad++; $display("FAIL fifo%0d gap: got %0d want 0", i, wt); end
            end
        end
        total++;
        if (empty_o !== 1'b1) begin bad++; $display("FAIL fifo drained empty: got %b want 1", empty_o); end
        idle_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_o !== 1'b1 || busy_o !== 1'b0) idle_ok = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!idle_ok) begin bad++; $display("FAIL fifo extra frame: got activity want idle"); end
    endtask

    task automatic test_baud_and_enable;
        logic [7:0] w;
        int wt, n;
        bit idle_ok;
        for (int d = 0; d < 2; d++) begin
            set_cfg(d, 6, 1, 1'b1);
            w = 8'($urandom);
            push(w);
            expect_frame(w, d, 6, 1, 1'b1, $sformatf("div%0d", d), wt);
            repeat (2) @(negedge clk);
        end
        tx_en = 1'b0;
        set_cfg(2, 8, 2, 1'b0);
        push(8'h6B);
        push(8'hD2);
        tx_en = 1'b1;
        n = 0;
        while (tx_o === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tx_en = 1'b0;
        expect_frame(8'h6B, 2, 8, 2, 1'b0, "en_drop", wt);
        idle_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (tx_o !== 1'b1 || busy_o !== 1'b0) idle_ok = 1'b0;
            @(negedge clk);
        end
        total += 2;
        if (!idle_ok)         begin bad++; $display("FAIL en_drop idle: got activity want idle"); end
        if (empty_o !== 1'b0) begin bad++; $display("FAIL en_drop queued: empty=%b want 0", empty_o); end
        tx_en = 1'b1;
        expect_frame(8'hD2, 2, 8, 2, 1'b0, "en_resume", wt);
        total++;
        if (empty_o !== 1'b1) begin bad++; $display("FAIL en_resume empty: got %b want 1", empty_o); end
    endtask

    task automatic test_random;
        logic [7:0] w;
        int d, l, p, wt;
        bit s;
        tx_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            w = 8'($urandom);
            d = $urandom_range(0, 5);
            l = $urandom_range(0, 15);
            p = $urandom_range(0, 3);
            s = 1'($urandom);
            set_cfg(d, l, p, s);
            push(w);
            expect_frame(w, d, l, p, s, $sformatf("rand%0d", k), wt);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        tx_en = 1'b0;
        set_cfg(3, 8, 0, 1'b0);
        push(8'h00);
        push(8'h3C);
        tx_en = 1'b1;
        n = 0;
        while (tx_o === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        total++;
        if (tx_o !== 1'b0) begin bad++; $display("FAIL pre-reset data: tx_o=%b want 0", tx_o); end
        #2 rst = 1'b1;
        #1;
        total += 3;
        if (tx_o !== 1'b1)   begin bad++; $display("FAIL async reset tx: got %b want 1", tx_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL async reset busy: got %b want 0", busy_o); end
        if (done_o !== 1'b0) begin bad++; $display("FAIL async reset done: got %b want 0", done_o); end
        @(negedge clk);
        rst   = 1'b0;
        tx_en = 1'b0;
        @(negedge clk);
        total += 2;
        if (empty_o !== 1'b1) begin bad++; $display("FAIL post-reset empty: got %b want 1", empty_o); end
        if (tx_o !== 1'b1)    begin bad++; $display("FAIL post-reset tx: got %b want 1", tx_o); end
    endtask

    initial begin
        rst      = 1'b1;
        tx_en    = 1'b0;
        tx_we    = 1'b0;
        din      = 8'h00;
        ovf_clr  = 1'b0;
        set_cfg(1, 8, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_fifo_full();
        test_baud_and_enable();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
